// File: rtl/mips_core_pkg.sv
// Shared core types: default register/queue widths and the active-list entry layout.
// No logic; constants and types only.
// Consumers import mips_core::* and size their ports from these defaults.
package mips_core;

   // Default active-list depth and register index widths
   localparam int RETIRE_DEPTH_DEF = 16;
   localparam int PHYS_W_DEF       = 6;
   localparam int ARCH_W_DEF       = 5;

   // One active-list slot. Payload fields use the package default widths;
   // instances with narrower parameters zero-extend into them.
   typedef struct packed {
      logic                  valid;
      logic                  done;
      logic                  uses_rw;
      logic [ARCH_W_DEF-1:0] arch;
      logic [PHYS_W_DEF-1:0] old_phys;
      logic [PHYS_W_DEF-1:0] new_phys;
   } retire_entry_t;

endpackage

// File: rtl/retire_unit.sv
// In-order retire (active list) with writeback marking, branch flush and free-list return.
// Latency: commit_* / free_* appear one cycle after the head is seen occupied and done.
// Backpressure: alloc_ready drops when the list is full or a flush is presented; RETIRE_STATS_EN adds counters.
module retire_unit
   import mips_core::*;
#(
   parameter  int DEPTH  = RETIRE_DEPTH_DEF,
   parameter  int PHYS_W = PHYS_W_DEF,
   parameter  int ARCH_W = ARCH_W_DEF,
   localparam int TAG_W  = $clog2(DEPTH)
)(
   input  logic              clk,
   input  logic              rst_n,
   // rename side
   input  logic              alloc_valid,
   output logic              alloc_ready,
   input  logic              alloc_uses_rw,
   input  logic [ARCH_W-1:0] alloc_arch,
   input  logic [PHYS_W-1:0] alloc_old_phys,
   input  logic [PHYS_W-1:0] alloc_new_phys,
   output logic [TAG_W-1:0]  alloc_tag,
   // completion
   input  logic              wb_valid,
   input  logic [TAG_W-1:0]  wb_tag,
   // mispredict recovery
   input  logic              flush_valid,
   input  logic [TAG_W-1:0]  flush_tag,
   // architectural commit
   output logic              commit_valid,
   output logic              commit_uses_rw,
   output logic [ARCH_W-1:0] commit_arch,
   output logic [PHYS_W-1:0] commit_new_phys,
   // free-list return
   output logic              free_valid,
   output logic [PHYS_W-1:0] free_phys,
   // status
   output logic [TAG_W:0]    count,
   output logic              empty
`ifdef RETIRE_STATS_EN
   ,
   output logic [31:0]       retired_count,
   output logic [31:0]       head_stall_cycles
`endif
);

   localparam int PTR_W = TAG_W + 1;

   retire_entry_t    mem [DEPTH];
   retire_entry_t    head_entry;

   // Pointers carry one extra wrap bit so full and empty are distinguishable
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [TAG_W-1:0] head_idx;
   logic [TAG_W-1:0] tail_idx;
   logic [TAG_W-1:0] flush_dist;

   logic             full;
   logic             alloc_fire;
   logic             retire_go;
   logic             wb_hit;
   logic             flush_hit;
   logic [DEPTH-1:0] squash;

   assign head_idx    = head[TAG_W-1:0];
   assign tail_idx    = tail[TAG_W-1:0];
   assign full        = (head_idx == tail_idx) && (head[TAG_W] != tail[TAG_W]);
   assign empty       = (head == tail);
   assign count       = tail - head;

   assign alloc_ready = !full && !flush_valid;
   assign alloc_tag   = tail_idx;
   assign alloc_fire  = alloc_valid && alloc_ready;

   // done is read from the register, so a same-cycle writeback only helps next cycle
   assign head_entry  = mem[head_idx];
   assign retire_go   = head_entry.valid && head_entry.done;

   // Writebacks and flushes naming an empty slot are stale and dropped
   assign wb_hit      = wb_valid && mem[wb_tag].valid;
   assign flush_hit   = flush_valid && mem[flush_tag].valid;

   // Age of the branch relative to head; anything older-or-equal survives
   assign flush_dist  = flush_tag - head_idx;

   // Select every occupied slot that is younger than the flushing branch
   always_comb begin
      squash = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (flush_hit && mem[i].valid && ((TAG_W'(i) - head_idx) > flush_dist)) begin
            squash[i] = 1'b1;
         end
      end
   end

   // Slot state: writeback marking, retire release, flush squash, allocation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (wb_hit) begin
            mem[wb_tag].done <= 1'b1;
         end
         // The head is never squashed (distance 0), so retire and flush never collide
         if (retire_go) begin
            mem[head_idx].valid <= 1'b0;
            mem[head_idx].done  <= 1'b0;
         end
         for (int i = 0; i < DEPTH; i++) begin
            if (squash[i]) begin
               mem[i].valid <= 1'b0;
               mem[i].done  <= 1'b0;
            end
         end
         // Tail slot is unoccupied when alloc fires, so no writeback can target it
         if (alloc_fire) begin
            mem[tail_idx].valid    <= 1'b1;
            mem[tail_idx].done     <= 1'b0;
            mem[tail_idx].uses_rw  <= alloc_uses_rw;
            mem[tail_idx].arch     <= ARCH_W_DEF'(alloc_arch);
            mem[tail_idx].old_phys <= PHYS_W_DEF'(alloc_old_phys);
            mem[tail_idx].new_phys <= PHYS_W_DEF'(alloc_new_phys);
         end
      end
   end

   // Head/tail advance; a flush rewinds tail to just past the branch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head <= '0;
         tail <= '0;
      end else begin
         if (retire_go) begin
            head <= head + PTR_W'(1);
         end
         // alloc_ready is low during a flush, so the two tail updates are exclusive
         if (flush_hit) begin
            tail <= head + PTR_W'(flush_dist) + PTR_W'(1);
         end else if (alloc_fire) begin
            tail <= tail + PTR_W'(1);
         end
      end
   end

   // Registered retire results, valid for exactly the cycle after the decision
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         commit_valid    <= 1'b0;
         commit_uses_rw  <= 1'b0;
         commit_arch     <= '0;
         commit_new_phys <= '0;
         free_valid      <= 1'b0;
         free_phys       <= '0;
      end else begin
         commit_valid <= retire_go;
         free_valid   <= retire_go && head_entry.uses_rw;
         if (retire_go) begin
            commit_uses_rw  <= head_entry.uses_rw;
            commit_arch     <= ARCH_W'(head_entry.arch);
            commit_new_phys <= PHYS_W'(head_entry.new_phys);
            free_phys       <= PHYS_W'(head_entry.old_phys);
         end
      end
   end

`ifdef RETIRE_STATS_EN
   // Free-running, wrapping retire and head-stall counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retired_count     <= '0;
         head_stall_cycles <= '0;
      end else begin
         if (commit_valid) begin
            retired_count <= retired_count + 32'd1;
         end
         if (!empty && !head_entry.done) begin
            head_stall_cycles <= head_stall_cycles + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_retire_unit.sv
// Directed bench for retire_unit with a queue-based reference model.
// Compare process samples at the falling edge; stimulus changes 1ns after the rising edge.
// Optional RETIRE_STATS_EN ports are connected when the macro is defined.
`timescale 1ns/1ps
module tb_retire_unit;
   import mips_core::*;

   localparam int DEPTH  = 16;
   localparam int PHYS_W = 6;
   localparam int ARCH_W = 5;
   localparam int TAG_W  = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              alloc_valid, alloc_ready, alloc_uses_rw;
   logic [ARCH_W-1:0] alloc_arch;
   logic [PHYS_W-1:0] alloc_old_phys, alloc_new_phys;
   logic [TAG_W-1:0]  alloc_tag;
   logic              wb_valid;
   logic [TAG_W-1:0]  wb_tag;
   logic              flush_valid;
   logic [TAG_W-1:0]  flush_tag;
   logic              commit_valid, commit_uses_rw;
   logic [ARCH_W-1:0] commit_arch;
   logic [PHYS_W-1:0] commit_new_phys;
   logic              free_valid;
   logic [PHYS_W-1:0] free_phys;
   logic [TAG_W:0]    count;
   logic              empty;
`ifdef RETIRE_STATS_EN
   logic [31:0]       retired_count, head_stall_cycles;
`endif

   always #5 clk = ~clk;

   retire_unit #(.DEPTH(DEPTH), .PHYS_W(PHYS_W), .ARCH_W(ARCH_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_uses_rw(alloc_uses_rw),
      .alloc_arch(alloc_arch), .alloc_old_phys(alloc_old_phys), .alloc_new_phys(alloc_new_phys),
      .alloc_tag(alloc_tag),
      .wb_valid(wb_valid), .wb_tag(wb_tag),
      .flush_valid(flush_valid), .flush_tag(flush_tag),
      .commit_valid(commit_valid), .commit_uses_rw(commit_uses_rw),
      .commit_arch(commit_arch), .commit_new_phys(commit_new_phys),
      .free_valid(free_valid), .free_phys(free_phys),
      .count(count), .empty(empty)
`ifdef RETIRE_STATS_EN
      , .retired_count(retired_count), .head_stall_cycles(head_stall_cycles)
`endif
   );

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- reference model: program-order queue ----------------
   typedef struct {
      int tag;
      bit uses;
      int arch;
      int oldp;
      int newp;
      bit done;
   } ment_t;

   ment_t mq[$];
   int    m_head = 0;
   bit    e_cv = 0, e_fv = 0, e_cu = 0;
   int    e_arch = 0, e_new = 0, e_fphys = 0;

   task automatic model_step();
      int    size_pre, tail_pre, k;
      bit    ret;
      ment_t n;
      size_pre = mq.size();
      tail_pre = (m_head + size_pre) % DEPTH;
      ret      = (size_pre > 0) && mq[0].done;
      e_cv     = ret;
      e_fv     = ret && mq[0].uses;
      if (ret) begin
         e_cu    = mq[0].uses;
         e_arch  = mq[0].arch;
         e_new   = mq[0].newp;
         e_fphys = mq[0].oldp;
      end
      if (flush_valid) begin
         k = -1;
         foreach (mq[j]) if (mq[j].tag == int'(flush_tag)) k = j;
         if (k >= 0) mq = mq[0:k];
      end
      if (ret) begin
         mq.delete(0);
         m_head = (m_head + 1) % DEPTH;
      end
      if (wb_valid) foreach (mq[j]) if (mq[j].tag == int'(wb_tag)) mq[j].done = 1'b1;
      if (alloc_valid && !flush_valid && size_pre < DEPTH) begin
         n.tag  = tail_pre;
         n.uses = alloc_uses_rw;
         n.arch = int'(alloc_arch);
         n.oldp = int'(alloc_old_phys);
         n.newp = int'(alloc_new_phys);
         n.done = 1'b0;
         mq.push_back(n);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         m_head = 0;
         e_cv   = 0;
         e_fv   = 0;
      end else begin
         cyc++;
         model_step();
      end
   end

   // ---------------- commit log + per-cycle compare ----------------
   int lg_arch[$];
   int lg_free[$];
   int lg_cyc[$];

   always @(negedge clk) begin
      if (rst_n) begin
         chk("count",        count,        mq.size());
         chk("empty",        empty,        mq.size() == 0);
         chk("alloc_ready",  alloc_ready,  (mq.size() < DEPTH) && !flush_valid);
         chk("alloc_tag",    alloc_tag,    (m_head + mq.size()) % DEPTH);
         chk("commit_valid", commit_valid, e_cv);
         chk("free_valid",   free_valid,   e_fv);
         if (e_cv) begin
            chk("commit_arch",     commit_arch,     e_arch);
            chk("commit_new_phys", commit_new_phys, e_new);
            chk("commit_uses_rw",  commit_uses_rw,  e_cu);
         end
         if (e_fv) chk("free_phys", free_phys, e_fphys);
         if (commit_valid) begin
            lg_arch.push_back(int'(commit_arch));
            lg_free.push_back(free_valid ? int'(free_phys) : -1);
            lg_cyc.push_back(cyc);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive(input bit av, input bit uses, input int arch, input int op, input int np,
                        input bit wv, input int wt, input bit fv, input int ft);
      alloc_valid    = av;
      alloc_uses_rw  = uses;
      alloc_arch     = ARCH_W'(arch);
      alloc_old_phys = PHYS_W'(op);
      alloc_new_phys = PHYS_W'(np);
      wb_valid       = wv;
      wb_tag         = TAG_W'(wt);
      flush_valid    = fv;
      flush_tag      = TAG_W'(ft);
      @(posedge clk);
      #1;
   endtask

   task automatic do_alloc(input bit uses, input int arch, input int op, input int np);
      drive(1'b1, uses, arch, op, np, 1'b0, 0, 1'b0, 0);
   endtask

   task automatic do_wb(input int t);
      drive(1'b0, 1'b0, 0, 0, 0, 1'b1, t, 1'b0, 0);
   endtask

   task automatic do_flush(input int t);
      drive(1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 1'b1, t);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 1'b0, 0);
   endtask

   task automatic set_idle();
      alloc_valid = 1'b0; alloc_uses_rw = 1'b0; alloc_arch = '0;
      alloc_old_phys = '0; alloc_new_phys = '0;
      wb_valid = 1'b0; wb_tag = '0; flush_valid = 1'b0; flush_tag = '0;
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge
   task automatic do_reset();
      set_idle();
      rst_n = 1'b0;
      #1;
      chk("rst_empty",        empty,        1);
      chk("rst_count",        count,        0);
      chk("rst_commit_valid", commit_valid, 0);
      chk("rst_free_valid",   free_valid,   0);
      chk("rst_alloc_ready",  alloc_ready,  1);
      lg_arch.delete();
      lg_free.delete();
      lg_cyc.delete();
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      set_idle();
      @(posedge clk);
      #1;

      // 1: three entries, out-of-order completion, in-order commit
      do_reset();
      do_alloc(1, 1, 1, 32);
      do_alloc(1, 2, 2, 33);
      do_alloc(1, 3, 3, 34);
      do_wb(2);
      do_wb(0);
      do_wb(1);
      idle(5);
      chk("s1_ncommit", lg_arch.size(), 3);
      if (lg_arch.size() == 3) begin
         for (int i = 0; i < 3; i++) begin
            chk("s1_arch", lg_arch[i], i + 1);
            chk("s1_free", lg_free[i], i + 1);
         end
         chk("s1_consec_a", lg_cyc[1] - lg_cyc[0], 1);
         chk("s1_consec_b", lg_cyc[2] - lg_cyc[1], 1);
      end

      // 2: fill to DEPTH, refuse, retire one, wrap the tail to slot 0
      do_reset();
      for (int i = 0; i < DEPTH; i++) do_alloc(1, i, i, i + 32);
      set_idle();
      #1;
      chk("s2_full_count", count, 16);
      chk("s2_full_rdy",   alloc_ready, 0);
      do_alloc(1, 20, 20, 60);
      do_wb(0);
      idle(1);
      chk("s2_count15", count, 15);
      chk("s2_rdy",     alloc_ready, 1);
      chk("s2_wraptag", alloc_tag, 0);
      do_alloc(1, 21, 40, 50);
      for (int i = 1; i < DEPTH; i++) do_wb(i);
      do_wb(0);
      idle(6);
      chk("s2_ncommit", lg_arch.size(), 17);
      if (lg_arch.size() == 17) chk("s2_wrap_arch", lg_arch[16], 21);
      chk("s2_drained", empty, 1);

      // 3: flush on tag 2 squashes 3..5 silently, next alloc reuses tag 3
      do_reset();
      for (int i = 0; i < 6; i++) do_alloc(1, i + 1, i + 10, i + 20);
      do_flush(2);
      chk("s3_count", count, 3);
      chk("s3_tail",  alloc_tag, 3);
      do_alloc(1, 9, 30, 40);
      for (int i = 0; i < 6; i++) do_wb(i);
      idle(6);
      chk("s3_ncommit", lg_arch.size(), 4);
      if (lg_arch.size() == 4) begin
         chk("s3_arch3", lg_arch[3], 9);
         chk("s3_free2", lg_free[2], 12);
      end

      // 4: stale writeback to unoccupied tag 7 is dropped
      do_reset();
      for (int i = 0; i < 4; i++) do_alloc(1, i + 1, i, i + 40);
      do_wb(7);
      for (int i = 4; i < 8; i++) do_alloc(1, i + 1, i, i + 40);
      for (int i = 0; i < 7; i++) do_wb(i);
      idle(10);
      chk("s4_ncommit", lg_arch.size(), 7);
      chk("s4_pending", count, 1);
      do_wb(7);
      idle(3);
      chk("s4_ncommit_b", lg_arch.size(), 8);
      if (lg_arch.size() == 8) chk("s4_arch7", lg_arch[7], 8);

      // 5: non-writing instruction commits without a free
      do_reset();
      do_alloc(0, 5, 7, 8);
      do_wb(0);
      idle(3);
      chk("s5_ncommit", lg_arch.size(), 1);
      if (lg_arch.size() == 1) chk("s5_nofree", lg_free[0], -1);

      // 6: reset while five entries are pending (head already done)
      do_reset();
      for (int i = 0; i < 5; i++) do_alloc(1, i + 1, i + 1, i + 33);
      for (int i = 4; i >= 0; i--) do_wb(i);
      chk("s6_pre_commit", lg_arch.size(), 0);
      do_reset();
      idle(6);
      chk("s6_no_commit", lg_arch.size(), 0);
      chk("s6_empty",     empty, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/retire_unit.md
RETIRE_UNIT -- requirements
Module: retire_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 16: active-list entries, power of two, minimum 4.
REQ-002 SHALL have parameter PHYS_W, default 6: physical register index width.
REQ-003 SHALL have parameter ARCH_W, default 5: architectural register index width.
REQ-004 SHALL have derived localparam TAG_W = log2(DEPTH).
REQ-005 SHALL have one clock, clk (in, 1 bit, rising edge), and reset rst_n (in, 1 bit); reset is asynchronous and active-low.
REQ-006 SHALL have the alloc ports:
- alloc_valid, in, 1: rename offers an entry.
- alloc_ready, out, 1: entry accepted this cycle.
- alloc_uses_rw, in, 1: instruction writes a register.
- alloc_arch, in, ARCH_W: destination architectural register.
- alloc_old_phys, in, PHYS_W: previous mapping, freed at retire.
- alloc_new_phys, in, PHYS_W: new mapping.
- alloc_tag, out, TAG_W: slot index assigned to the offered entry.
REQ-007 SHALL have the writeback ports:
- wb_valid, in, 1: a result completed.
- wb_tag, in, TAG_W: tag of the completed instruction.
REQ-008 SHALL have the flush ports:
- flush_valid, in, 1: mispredict recovery.
- flush_tag, in, TAG_W: branch tag; all younger entries are squashed.
REQ-009 SHALL have the commit ports, all out:
- commit_valid, 1: one instruction retired.
- commit_uses_rw, 1.
- commit_arch, ARCH_W.
- commit_new_phys, PHYS_W: architectural map update.
REQ-010 SHALL have the free-list return ports, all out:
- free_valid, 1.
- free_phys, PHYS_W: register returned to the free list.
REQ-011 SHALL have the status ports, all out:
- count, TAG_W+1: occupied entries.
- empty, 1.

Function
REQ-012 SHALL keep a circular buffer with head/tail pointers of TAG_W+1 bits (extra wrap bit); full = same index and differing wrap bits; empty = pointers equal.
REQ-013 SHALL drive alloc_ready = !full && !flush_valid, combinationally.
REQ-014 SHALL drive alloc_tag = the tail index, combinationally.
REQ-015 SHALL, on alloc_valid && alloc_ready, write the entry at tail with done=0 and advance tail by one at the clock edge.
REQ-016 SHALL, on wb_valid, set done for wb_tag only if that slot is occupied; a writeback to an unoccupied slot SHALL be ignored.
REQ-017 SHALL retire at most one entry per cycle, when the head entry is occupied and its registered done=1; head SHALL then advance by one.
REQ-018 SHALL register the retire results: commit_* and free_* are valid the cycle after the retire decision and held for exactly one cycle.
REQ-019 SHALL drive free_valid = commit_valid && commit_uses_rw, and free_phys = the retired entry's old_phys.
REQ-020 SHALL give a writeback and a retire-check on the same entry in the same cycle no effect until the next cycle: done is sampled pre-edge, so the entry retires one cycle later.
REQ-021 SHALL, on flush_valid with flush_tag occupied, set tail to flush_tag+1 (wrap bit adjusted) and invalidate all younger entries without emitting free_valid for them, since the renamer restores its own free list.
REQ-022 SHALL ignore flush_valid when flush_tag is unoccupied.
REQ-023 SHALL let a retire of the head proceed normally in the same cycle as a flush, and that retire SHALL take effect.
REQ-024 SHALL accept pointer wrap-around at DEPTH-1 -> 0 transparently; count SHALL stay correct across wrap and SHALL reach DEPTH when full.
REQ-025 SHALL compute count = tail - head modulo 2^(TAG_W+1).

Reset
REQ-026 SHALL, on rst_n low at any time, immediately (asynchronously) clear head, tail, all valid/done bits, commit_valid and free_valid.
REQ-027 SHALL reset all other registered outputs to 0; after reset, empty=1, count=0 and alloc_ready=1.
REQ-028 SHALL lose in-flight entries when reset is asserted mid-operation, and SHALL issue no free_valid for them.

Configuration
REQ-029 SHALL, with RETIRE_STATS_EN defined, add 32-bit outputs retired_count and head_stall_cycles.
- retired_count increments per commit_valid.
- head_stall_cycles increments each cycle the buffer is non-empty and the head is not done.
- Both counters wrap and reset to 0.
REQ-030 SHALL, without RETIRE_STATS_EN, omit these ports and counters entirely.

Structure
REQ-031 SHALL place the retire_entry_t struct (valid, done, uses_rw, arch, old_phys, new_phys) and the default width constants in the shared mips_core package.
REQ-032 SHALL be a single module; no sub-module is warranted.

Verification
REQ-033 Bench SHALL cover these directed scenarios:
- Reset, then alloc 3 entries (arch 1/2/3, old 1/2/3, new 32/33/34), wb tags 2,0,1 -> commits in order 1,2,3 on consecutive cycles, free_phys 1,2,3.
- Fill 16 entries -> alloc_ready=0 and count=16; retire one -> alloc_ready=1 and the next alloc_tag=0 (wrap).
- Alloc tags 0-5, flush_tag=2 -> count=3, tail=3, no free_valid for tags 3-5; the next alloc_tag=3.
- wb_tag=7 while only tags 0-3 are occupied -> ignored; the tag-7 alloc made later still requires its own wb.
- Alloc with alloc_uses_rw=0 retires -> commit_valid=1, free_valid=0.
- Assert rst_n low while 5 entries are pending -> empty=1 and commit_valid=0 immediately, no commits after release.
